// File: rtl/cq_parser.sv
// rtl/cq_parser.sv - CQ request decoder: strips the descriptor, realigns write payload to DW0
// and emits one PIO request packet per TLP with a pre-built completion head in tuser.
module cq_parser #(
  localparam int PIO_DATA_W = 256,
  localparam int PIO_KEEP_W = 8,
  localparam int PIO_USER_W = 140
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIO_DATA_W-1:0] cq_tdata,
  input  logic [87:0]           cq_tuser,
  input  logic                  cq_tlast,
  input  logic [7:0]            cq_tkeep,
  input  logic                  cq_tvalid,
  output logic                  cq_tready,
  output logic [PIO_DATA_W-1:0] m_axis_req_tdata,
  output logic [PIO_USER_W-1:0] m_axis_req_tuser,
  output logic [PIO_KEEP_W-1:0] m_axis_req_tkeep,
  output logic                  m_axis_req_tlast,
  output logic                  m_axis_req_tvalid,
  input  logic                  m_axis_req_tready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_RD,
    S_DROP
  } state_t;

  localparam logic [3:0] TYPE_MEMRD = 4'b0000;
  localparam logic [3:0] TYPE_MEMWR = 4'b0001;

  state_t                  state_q, state_d;
  logic [127:0]            hold_q;
  logic [11:0]             dw_left_q;
  logic [PIO_USER_W-1:0]   tuser_q;

  logic [3:0]  req_type;
  logic [10:0] dw_cnt;
  logic [11:0] dw_full;
  logic [3:0]  first_be, last_be;
  logic [1:0]  lo_off, hi_gap;
  logic [12:0] byte_cnt;
  logic [31:0] ap_mask, aligned_addr;
  logic [95:0] cc_head;
  logic [PIO_USER_W-1:0] tuser_d;

  logic                  ld_hdr, adv;
  logic                  cq_rdy, m_valid, m_last;
  logic [PIO_DATA_W-1:0] m_data;
  logic [PIO_KEEP_W-1:0] m_keep, keep_left;
  logic                  stream_last;

  logic unused_inputs;
  assign unused_inputs = ^{cq_tkeep, cq_tuser[87:12], cq_tuser[7:4],
                           cq_tdata[63:32], cq_tdata[79], cq_tdata[111:104], cq_tdata[127]};

  assign req_type = cq_tdata[78:75];
  assign dw_cnt   = cq_tdata[74:64];
  assign dw_full  = (dw_cnt == 11'd0) ? 12'd1024 : {1'b0, dw_cnt};
  assign first_be = cq_tuser[3:0];
  assign last_be  = cq_tuser[11:8];

  always_comb begin
    lo_off = 2'd0;
    casez (first_be)
      4'b???1: lo_off = 2'd0;
      4'b??10: lo_off = 2'd1;
      4'b?100: lo_off = 2'd2;
      4'b1000: lo_off = 2'd3;
      default: lo_off = 2'd0;
    endcase
  end

  // Leading zeros of last_be from bit 3; an empty mask saturates at 3.
  always_comb begin
    hi_gap = 2'd3;
    casez (last_be)
      4'b1???: hi_gap = 2'd0;
      4'b01??: hi_gap = 2'd1;
      4'b001?: hi_gap = 2'd2;
      default: hi_gap = 2'd3;
    endcase
  end

  always_comb begin
    byte_cnt = 13'd1;
    if (dw_cnt == 11'd1) begin
      casez (first_be)
        4'b1??1:                   byte_cnt = 13'd4;
        4'b01?1, 4'b1?10:          byte_cnt = 13'd3;
        4'b0011, 4'b0110, 4'b1100: byte_cnt = 13'd2;
        default:                   byte_cnt = 13'd1;
      endcase
    end else begin
      byte_cnt = {dw_full[10:0], 2'b00} - {11'd0, lo_off} - {11'd0, hi_gap};
    end
  end

  assign ap_mask      = cq_tdata[120] ? 32'hFFFF_FFFF
                                      : ((32'd1 << cq_tdata[119:115]) - 32'd1);
  assign aligned_addr = {cq_tdata[31:2], 2'b00} & ap_mask;

  assign cc_head = {1'b0, cq_tdata[126:124], cq_tdata[123:121], 17'd0,
                    cq_tdata[103:96], cq_tdata[95:80], 5'd0, dw_cnt,
                    3'd0, byte_cnt, 6'd0, cq_tdata[1:0], 1'b0,
                    cq_tdata[6:2], lo_off};

  assign tuser_d = {(req_type == TYPE_MEMWR), cq_tdata[114:112], first_be, last_be,
                    aligned_addr, cc_head};

  assign stream_last = (dw_left_q <= 12'd8);
  assign keep_left   = (|dw_left_q[11:3]) ? 8'hFF
                                          : (8'hFF >> (4'd8 - {1'b0, dw_left_q[2:0]}));

  always_comb begin
    state_d = state_q;
    cq_rdy  = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_keep  = '0;
    m_last  = 1'b0;
    ld_hdr  = 1'b0;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cq_rdy = 1'b1;
        if (cq_tvalid) begin
          ld_hdr = 1'b1;
          if (req_type == TYPE_MEMRD)
            state_d = cq_tlast ? S_RD : S_DROP;
          else if (req_type == TYPE_MEMWR)
            state_d = cq_tlast ? S_FLUSH : S_STREAM;
          else
            state_d = cq_tlast ? S_IDLE : S_DROP;
        end
      end
      S_STREAM: begin
        // Output beat = low half of the incoming beat over the held upper half of the previous one.
        m_valid = cq_tvalid;
        cq_rdy  = m_axis_req_tready;
        m_data  = {cq_tdata[127:0], hold_q};
        m_last  = stream_last;
        m_keep  = keep_left;
        if (cq_tvalid && m_axis_req_tready) begin
          adv = 1'b1;
          if (stream_last)
            state_d = S_IDLE;
          else if (cq_tlast)
            state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        m_valid = 1'b1;
        m_data  = {128'd0, hold_q};
        m_last  = 1'b1;
        m_keep  = keep_left;
        if (m_axis_req_tready)
          state_d = S_IDLE;
      end
      S_RD: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        if (m_axis_req_tready)
          state_d = S_IDLE;
      end
      S_DROP: begin
        cq_rdy = 1'b1;
        if (cq_tvalid && cq_tlast)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      cq_rdy  = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
      m_keep  = '0;
      m_last  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      dw_left_q <= '0;
      tuser_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ld_hdr) begin
        hold_q    <= cq_tdata[255:128];
        dw_left_q <= dw_full;
        tuser_q   <= tuser_d;
      end else if (adv) begin
        hold_q    <= cq_tdata[255:128];
        dw_left_q <= dw_left_q - 12'd8;
      end
    end
  end

  assign cq_tready         = cq_rdy;
  assign m_axis_req_tvalid = m_valid;
  assign m_axis_req_tdata  = m_data;
  assign m_axis_req_tkeep  = m_keep;
  assign m_axis_req_tlast  = m_last;
  assign m_axis_req_tuser  = rst ? '0 : tuser_q;

endmodule

// File: tb/tb_cq_parser.sv
// tb/tb_cq_parser.sv - scoreboard bench for cq_parser: randomized TLPs against a
// behavioural request model, with a decoupled output monitor.
module tb_cq_parser;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] cq_tdata;
  logic [87:0]  cq_tuser;
  logic         cq_tlast;
  logic [7:0]   cq_tkeep;
  logic         cq_tvalid;
  logic         cq_tready;
  logic [255:0] m_tdata;
  logic [139:0] m_tuser;
  logic [7:0]   m_tkeep;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready;

  always #5 clk = ~clk;

  cq_parser dut (
    .clk               (clk),
    .rst               (rst),
    .cq_tdata          (cq_tdata),
    .cq_tuser          (cq_tuser),
    .cq_tlast          (cq_tlast),
    .cq_tkeep          (cq_tkeep),
    .cq_tvalid         (cq_tvalid),
    .cq_tready         (cq_tready),
    .m_axis_req_tdata  (m_tdata),
    .m_axis_req_tuser  (m_tuser),
    .m_axis_req_tkeep  (m_tkeep),
    .m_axis_req_tlast  (m_tlast),
    .m_axis_req_tvalid (m_tvalid),
    .m_axis_req_tready (m_tready)
  );

  typedef struct {
    logic [255:0] data;
    logic [7:0]   keep;
    logic         last;
    logic [139:0] user;
  } beat_t;

  typedef struct {
    int          typ;
    int          n_raw;
    logic [63:0] addr;
    logic [1:0]  at;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [7:0]  tag;
    logic [15:0] req_id;
    logic [2:0]  bar;
    logic [5:0]  ap;
    logic [2:0]  tc;
    logic [2:0]  attr;
    int          nbeats;
  } tlp_t;

  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    rdy_mode = 2;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  function automatic int lowest_set(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return -1;
  endfunction

  function automatic int highest_set(input logic [3:0] b);
    for (int i = 3; i >= 0; i--) if (b[i]) return i;
    return -1;
  endfunction

  // Byte count is the byte span actually enabled across the request.
  function automatic int model_byte_cnt(input int n_raw, input logic [3:0] fbe, input logic [3:0] lbe);
    int n, lo, gap;
    n  = (n_raw == 0) ? 1024 : n_raw;
    lo = (fbe == 4'd0) ? 0 : lowest_set(fbe);
    if (n_raw == 1) return (fbe == 4'd0) ? 1 : highest_set(fbe) - lowest_set(fbe) + 1;
    gap = (lbe == 4'd0) ? 3 : 3 - highest_set(lbe);
    return 4 * n - lo - gap;
  endfunction

  function automatic logic [139:0] model_user(input tlp_t t);
    logic [63:0] a;
    logic [95:0] cc;
    int          bc, lo;
    a  = {32'd0, t.addr[31:2], 2'b00};
    if (t.ap < 6'd32) a = a % (64'd1 << t.ap);
    lo = (t.fbe == 4'd0) ? 0 : lowest_set(t.fbe);
    bc = model_byte_cnt(t.n_raw, t.fbe, t.lbe);
    cc = '0;
    cc[94:92] = t.attr;
    cc[91:89] = t.tc;
    cc[71:64] = t.tag;
    cc[63:48] = t.req_id;
    cc[42:32] = t.n_raw[10:0];
    cc[28:16] = bc[12:0];
    cc[9:8]   = t.at;
    cc[6:2]   = t.addr[6:2];
    cc[1:0]   = lo[1:0];
    return {(t.typ == 1), t.bar, t.fbe, t.lbe, a[31:0], cc};
  endfunction

  task automatic send_beat(input logic [255:0] d, input logic [87:0] u, input logic l, input bit body);
    int cyc = 0;
    bit acc = 0;
    cq_tdata  = d;
    cq_tuser  = u;
    cq_tlast  = l;
    cq_tkeep  = 8'($urandom_range(0, 255));
    cq_tvalid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = cq_tready;
      if (body) check("cq_tready_tracks_m_tready", {255'd0, cq_tready}, {255'd0, m_tready});
      @(posedge clk);
      #1;
      cyc++;
      if (!acc && cyc > 500) begin
        fail("cq_accept_timeout");
        acc = 1;
      end
    end
    cq_tvalid = 1'b0;
  endtask

  // max_beats < 0 sends the whole TLP; otherwise only that many CQ beats are issued.
  task automatic send_tlp(input tlp_t t, input logic [31:0] pay[$], input int max_beats);
    logic [127:0] desc;
    logic [31:0]  flat[$];
    logic [87:0]  u;
    logic [255:0] d;
    beat_t        b;
    int           n, nb, nout, nsend;
    n    = (t.n_raw == 0) ? 1024 : t.n_raw;
    desc = '0;
    desc[63:0]    = {t.addr[63:2], t.at};
    desc[74:64]   = t.n_raw[10:0];
    desc[78:75]   = t.typ[3:0];
    desc[95:80]   = t.req_id;
    desc[103:96]  = t.tag;
    desc[114:112] = t.bar;
    desc[120:115] = t.ap;
    desc[123:121] = t.tc;
    desc[126:124] = t.attr;
    for (int i = 0; i < 4; i++) flat.push_back(desc[32*i +: 32]);
    if (t.typ == 1) begin
      for (int i = 0; i < n; i++) flat.push_back(pay[i]);
      nb = (4 + n + 7) / 8;
    end else if (t.typ == 0) nb = 1;
    else nb = t.nbeats;
    while (flat.size() < nb * 8) flat.push_back((t.typ == 1) ? 32'd0 : $urandom);
    u        = '0;
    u[31:0]  = $urandom;
    u[63:32] = $urandom;
    u[87:64] = 24'($urandom);
    u[3:0]   = t.fbe;
    u[11:8]  = t.lbe;
    nsend = (max_beats < 0) ? nb : max_beats;
    if (t.typ == 1) begin
      nout = (n + 7) / 8;
      if (max_beats >= 0 && nout > max_beats - 1) nout = max_beats - 1;
      for (int k = 0; k < nout; k++) begin
        b.data = '0;
        b.keep = '0;
        for (int j = 0; j < 8; j++) begin
          if (8 * k + j < n) begin
            b.data[32*j +: 32] = pay[8*k + j];
            b.keep[j] = 1'b1;
          end
        end
        b.last = (8 * k + 8 >= n);
        b.user = model_user(t);
        exp_q.push_back(b);
      end
    end else if (t.typ == 0 && nsend >= 1) begin
      b.data = '0;
      b.keep = '0;
      b.last = 1'b1;
      b.user = model_user(t);
      exp_q.push_back(b);
    end
    for (int bi = 0; bi < nsend; bi++) begin
      if (bi > 0) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      d = '0;
      for (int j = 0; j < 8; j++) d[32*j +: 32] = flat[8*bi + j];
      send_beat(d, u, (bi == nb - 1), (t.typ == 1 && bi > 0));
    end
  endtask

  function automatic tlp_t mk(input int typ, input int n, input logic [63:0] addr,
                              input logic [3:0] fbe, input logic [3:0] lbe,
                              input logic [7:0] tag, input logic [15:0] req_id);
    tlp_t t;
    t.typ = typ; t.n_raw = n; t.addr = addr; t.at = 2'd0;
    t.fbe = fbe; t.lbe = lbe; t.tag = tag; t.req_id = req_id;
    t.bar = 3'd0; t.ap = 6'd40; t.tc = 3'd0; t.attr = 3'd0; t.nbeats = 1;
    return t;
  endfunction

  function automatic tlp_t rand_tlp();
    tlp_t t;
    int   r;
    r = $urandom_range(0, 9);
    t.typ = (r < 4) ? 0 : (r < 8) ? 1 : $urandom_range(2, 15);
    if (t.typ == 1) t.n_raw = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 64) : $urandom_range(1, 20);
    else t.n_raw = ($urandom_range(0, 2) == 0) ? 1 : $urandom_range(0, 1023);
    t.addr   = {$urandom, $urandom};
    t.at     = 2'($urandom_range(0, 3));
    t.fbe    = 4'($urandom_range(0, 15));
    t.lbe    = 4'($urandom_range(0, 15));
    t.tag    = 8'($urandom_range(0, 255));
    t.req_id = 16'($urandom_range(0, 65535));
    t.bar    = 3'($urandom_range(0, 7));
    t.ap     = 6'($urandom_range(0, 63));
    t.tc     = 3'($urandom_range(0, 7));
    t.attr   = 3'($urandom_range(0, 7));
    t.nbeats = $urandom_range(1, 3);
    return t;
  endfunction

  task automatic rand_payload(input int n, output logic [31:0] pay[$]);
    pay = {};
    for (int i = 0; i < n; i++) pay.push_back($urandom);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_cq_tready"}, {255'd0, cq_tready}, 256'd0);
    check({tag, "_m_tvalid"}, {255'd0, m_tvalid}, 256'd0);
    check({tag, "_m_tdata"}, m_tdata, 256'd0);
    check({tag, "_m_tkeep"}, {248'd0, m_tkeep}, 256'd0);
    check({tag, "_m_tlast"}, {255'd0, m_tlast}, 256'd0);
    check({tag, "_m_tuser"}, {116'd0, m_tuser}, 256'd0);
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() > 0 && c < 3000) begin @(posedge clk); c++; end
    if (exp_q.size() > 0) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = ($urandom_range(0, 3) != 0);
        1:       m_tready = ~m_tready;
        default: m_tready = 1'b1;
      endcase
    end
  end

  // Monitor: pops one expected beat per output handshake and checks stall stability.
  initial begin
    bit    stalled = 0;
    beat_t held, e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else if (m_tvalid) begin
        if (stalled) begin
          check("stall_tdata", m_tdata, held.data);
          check("stall_tuser", {116'd0, m_tuser}, {116'd0, held.user});
        end
        if (m_tready) begin
          stalled = 0;
          if (exp_q.size() == 0) fail("unexpected_output_beat");
          else begin
            e = exp_q.pop_front();
            check("out_tdata", m_tdata, e.data);
            check("out_tkeep", {248'd0, m_tkeep}, {248'd0, e.keep});
            check("out_tlast", {255'd0, m_tlast}, {255'd0, e.last});
            check("out_tuser", {116'd0, m_tuser}, {116'd0, e.user});
          end
        end else begin
          stalled = 1;
          held.data = m_tdata;
          held.user = m_tuser;
        end
      end else if (stalled) begin
        fail("tvalid_dropped_while_stalled");
        stalled = 0;
      end
    end
  end

  initial begin
    #900000;
    fail("global_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    tlp_t        t;
    logic [31:0] pay[$];
    rst = 1'b1;
    cq_tdata = '0; cq_tuser = '0; cq_tlast = 1'b0; cq_tkeep = '0; cq_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    rdy_mode = 2;
    pay = {};
    send_tlp(mk(0, 1, 64'h1004, 4'h3, 4'h0, 8'h2A, 16'h0100), pay, -1);
    send_tlp(mk(0, 4, 64'h40, 4'hE, 4'h7, 8'h11, 16'h0203), pay, -1);
    pay = {32'hD0D0_0000, 32'hD1D1_1111};
    send_tlp(mk(1, 2, 64'h2000, 4'hF, 4'hF, 8'h05, 16'h0100), pay, -1);
    rand_payload(12, pay);
    send_tlp(mk(1, 12, 64'h3000, 4'hF, 4'hF, 8'h06, 16'h0100), pay, -1);
    wait_drain();

    rdy_mode = 1;
    rand_payload(8, pay);
    send_tlp(mk(1, 8, 64'h4000, 4'hF, 4'hF, 8'h07, 16'h0100), pay, -1);
    wait_drain();

    rdy_mode = 2;
    t = mk(2, 1, 64'h5000, 4'hF, 4'h0, 8'h08, 16'h0100);
    send_tlp(t, pay, -1);
    send_tlp(mk(0, 1, 64'h6008, 4'h8, 4'h0, 8'h09, 16'h0100), pay, -1);
    wait_drain();

    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      t = rand_tlp();
      rand_payload((t.n_raw == 0) ? 1024 : t.n_raw, pay);
      send_tlp(t, pay, -1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_drain();

    rdy_mode = 2;
    @(posedge clk);
    #1;
    rand_payload(24, pay);
    send_tlp(mk(1, 24, 64'h7000, 4'hF, 4'hF, 8'h0A, 16'h0100), pay, 2);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("midrst_a");
    check("midrst_queue_empty", 256'(exp_q.size()), 256'd0);
    @(posedge clk);
    @(negedge clk);
    check_quiet("midrst_b");
    @(posedge clk);
    #1;
    rst = 1'b0;
    rand_payload(12, pay);
    send_tlp(mk(1, 12, 64'h8000, 4'h6, 4'h3, 8'h0B, 16'h0100), pay, -1);
    send_tlp(mk(0, 0, 64'h9004, 4'h2, 4'h1, 8'h0C, 16'h0100), pay, -1);
    wait_drain();
    repeat (4) @(posedge clk);
    check("final_queue_empty", 256'(exp_q.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
